// File: rtl/obstacle_manager_if.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_manager_if
// Brief    : Control inputs and obstacle-array outputs of obstacle_manager.
// Revision : 1.0 - initial release
// ============================================================================
interface obstacle_manager_if;
  logic         enable_in;
  logic         frame_tick_in;
  logic [2:0]   speed_in;
  logic [1:0]   player_lane_in;
  logic         player_jump_in;
  logic [149:0] obstacles_out;
  logic         update_done_out;
  logic         collision_out;
  logic         spawn_dropped_out;

  // Game-side driver of ticks and player state
  modport master (
    output enable_in, frame_tick_in, speed_in, player_lane_in, player_jump_in,
    input  obstacles_out, update_done_out, collision_out, spawn_dropped_out
  );

  // Obstacle manager side
  modport slave (
    input  enable_in, frame_tick_in, speed_in, player_lane_in, player_jump_in,
    output obstacles_out, update_done_out, collision_out, spawn_dropped_out
  );
endinterface
`default_nettype wire

// File: rtl/obstacle_manager.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_manager
// Brief    : Maintains the 10-slot obstacle array for the track renderer.
//            Each accepted frame tick moves, retires, collides and spawns
//            obstacles in a working copy, then commits it in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module obstacle_manager #(
  parameter logic [9:0]  SPAWN_POS = 10'd1000,
  parameter logic [10:0] SPAWN_GAP = 11'd300,
  parameter logic [9:0]  HIT_ZONE  = 10'd16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  wire logic          system_clock_in,
  input  wire logic          reset_in,
  obstacle_manager_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    SPAWN  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Working copy of the slots; slot i occupies bits [15*i+14:15*i]
  logic [9:0][14:0] work;
  logic [3:0]       idx;
  logic [2:0]       speed_l;
  logic [1:0]       lane_l;
  logic             jump_l;
  logic             hit;
  logic             dropped;
  logic [10:0]      distance;
  logic [15:0]      lfsr;

  logic             tick_accept;
  logic [14:0]      cur_slot;
  logic [9:0]       cur_pos;
  logic [9:0]       new_pos;
  logic [14:0]      move_slot;
  logic             move_hit;
  logic [15:0]      lfsr_next;
  logic [10:0]      sum;
  logic             free_found;
  logic [3:0]       free_idx;
  logic [1:0]       spawn_lane;
  logic [14:0]      spawn_slot;

  assign tick_accept = bus.frame_tick_in && bus.enable_in;

  // State register
  always_ff @(posedge system_clock_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic: IDLE -> MOVE x10 -> SPAWN -> COMMIT -> IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick_accept) state_next = MOVE;
      MOVE:    if (idx == 4'd9) state_next = SPAWN;
      SPAWN:   state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Move the current slot toward the player and test it against the player
  always_comb begin
    cur_slot  = work[idx];
    cur_pos   = cur_slot[12:3];
    new_pos   = '0;
    move_slot = cur_slot;
    move_hit  = 1'b0;
    if (cur_slot[0]) begin
      if (cur_pos < {7'd0, speed_l}) begin
        // Passed position 0: retire
        move_slot = '0;
      end else begin
        new_pos   = cur_pos - {7'd0, speed_l};
        move_slot = {cur_slot[14:13], new_pos, cur_slot[2:1], 1'b1};
        // Type 01 can be cleared by jumping; a hit removes the obstacle
        if ((new_pos < HIT_ZONE) && (cur_slot[2:1] == lane_l) &&
            !((cur_slot[14:13] == 2'b01) && jump_l)) begin
          move_hit  = 1'b1;
          move_slot = '0;
        end
      end
    end
  end

  // Spawn decision: LFSR step, distance accumulation, lowest free slot
  always_comb begin
    lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    sum        = distance + {8'd0, speed_l};
    spawn_lane = (lfsr_next[1:0] == 2'b11) ? 2'b00 : lfsr_next[1:0];
    spawn_slot = {lfsr_next[3:2], SPAWN_POS, spawn_lane, 1'b1};
    free_found = 1'b0;
    free_idx   = 4'd0;
    // Descending scan so the lowest-index free slot wins
    for (int i = 9; i >= 0; i--) begin
      if (!work[i][0]) begin
        free_found = 1'b1;
        free_idx   = i[3:0];
      end
    end
  end

  // Datapath: latch inputs, update working slots, commit and pulse outputs
  always_ff @(posedge system_clock_in) begin
    if (reset_in) begin
      work                  <= '0;
      idx                   <= 4'd0;
      speed_l               <= 3'd0;
      lane_l                <= 2'd0;
      jump_l                <= 1'b0;
      hit                   <= 1'b0;
      dropped               <= 1'b0;
      distance              <= 11'd0;
      lfsr                  <= LFSR_SEED;
      bus.obstacles_out     <= '0;
      bus.update_done_out   <= 1'b0;
      bus.collision_out     <= 1'b0;
      bus.spawn_dropped_out <= 1'b0;
    end else begin
      bus.update_done_out   <= 1'b0;
      bus.collision_out     <= 1'b0;
      bus.spawn_dropped_out <= 1'b0;
      case (state)
        IDLE: begin
          if (tick_accept) begin
            speed_l <= bus.speed_in;
            lane_l  <= bus.player_lane_in;
            jump_l  <= bus.player_jump_in;
            hit     <= 1'b0;
            dropped <= 1'b0;
            idx     <= 4'd0;
          end
        end
        MOVE: begin
          work[idx] <= move_slot;
          if (move_hit) hit <= 1'b1;
          idx <= (idx == 4'd9) ? 4'd0 : idx + 4'd1;
        end
        SPAWN: begin
          lfsr <= lfsr_next;
          if (sum >= SPAWN_GAP) begin
            distance <= sum - SPAWN_GAP;
            if (free_found) work[free_idx] <= spawn_slot;
            else            dropped        <= 1'b1;
          end else begin
            distance <= sum;
          end
        end
        COMMIT: begin
          bus.obstacles_out     <= work;
          bus.update_done_out   <= 1'b1;
          bus.collision_out     <= hit;
          bus.spawn_dropped_out <= dropped;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obstacle_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_obstacle_manager
// Brief    : Self-checking bench for obstacle_manager: directed vector table,
//            mid-update reset, and randomized frames against a slot model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obstacle_manager;

  localparam int GAP  = 3;
  localparam int SPOS = 1000;
  localparam int HZ   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  obstacle_manager_if bus ();

  obstacle_manager #(
    .SPAWN_POS (10'd1000),
    .SPAWN_GAP (11'd3),
    .HIT_ZONE  (10'd16),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .system_clock_in (clk),
    .reset_in        (rst),
    .bus             (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: plain per-slot records
  int          m_pos  [10];
  int          m_lane [10];
  int          m_type [10];
  bit          m_act  [10];
  int          m_dist;
  logic [15:0] m_lfsr;

  // Captured results of the last frame
  int           g_dones;
  int           g_first;
  bit           g_stable;
  logic [149:0] g_obs;
  logic         g_coll;
  logic         g_drop;

  typedef struct {
    bit          en;
    int          speed;
    int          lane;
    bit          jump;
    logic [14:0] exp_s0;
    logic [14:0] exp_s1;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [149:0] act, input logic [149:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      m_pos[i] = 0; m_lane[i] = 0; m_type[i] = 0; m_act[i] = 0;
    end
    m_dist = 0;
    m_lfsr = 16'hACE1;
  endtask

  function automatic logic [149:0] model_pack();
    logic [149:0] v;
    v = '0;
    for (int i = 0; i < 10; i++)
      v[15*i +: 15] = {m_type[i][1:0], m_pos[i][9:0], m_lane[i][1:0], m_act[i]};
    return v;
  endfunction

  task automatic model_clear(input int i);
    m_act[i] = 0; m_pos[i] = 0; m_lane[i] = 0; m_type[i] = 0;
  endtask

  task automatic model_frame(input int spd, input int pl, input bit pj,
                             output bit hit, output bit drop);
    int slot;
    hit  = 0;
    drop = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_act[i]) begin
        if (m_pos[i] < spd) model_clear(i);
        else begin
          m_pos[i] = m_pos[i] - spd;
          if (m_pos[i] < HZ && m_lane[i] == pl && !(m_type[i] == 1 && pj)) begin
            hit = 1;
            model_clear(i);
          end
        end
      end
    end
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    m_dist = m_dist + spd;
    if (m_dist >= GAP) begin
      m_dist = m_dist - GAP;
      slot = -1;
      for (int i = 9; i >= 0; i--) if (!m_act[i]) slot = i;
      if (slot < 0) drop = 1;
      else begin
        m_act[slot]  = 1;
        m_pos[slot]  = SPOS;
        m_type[slot] = int'(m_lfsr[3:2]);
        m_lane[slot] = (m_lfsr[1:0] == 2'b11) ? 0 : int'(m_lfsr[1:0]);
      end
    end
  endtask

  // Issue one tick and observe the DUT for 16 cycles
  task automatic run_frame(input bit en, input int spd, input int pl, input bit pj,
                           input bit inject, input logic [149:0] prev);
    @(negedge clk);
    bus.enable_in      = en;
    bus.speed_in       = spd[2:0];
    bus.player_lane_in = pl[1:0];
    bus.player_jump_in = pj;
    bus.frame_tick_in  = 1'b1;
    @(negedge clk);
    bus.frame_tick_in  = 1'b0;
    bus.speed_in       = 3'($urandom);
    bus.player_lane_in = 2'($urandom_range(0, 2));
    bus.player_jump_in = 1'($urandom);
    g_dones  = 0;
    g_first  = 0;
    g_stable = 1;
    g_obs    = bus.obstacles_out;
    g_coll   = 1'b0;
    g_drop   = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (bus.update_done_out) begin
        if (g_dones == 0) begin
          g_first = k;
          g_obs   = bus.obstacles_out;
          g_coll  = bus.collision_out;
          g_drop  = bus.spawn_dropped_out;
        end
        g_dones++;
      end else if (g_dones == 0 && bus.obstacles_out !== prev) begin
        g_stable = 0;
      end
      if (inject && k == 5) begin
        bus.enable_in     = 1'b1;
        bus.frame_tick_in = 1'b1;
      end
      if (k == 6) bus.frame_tick_in = 1'b0;
      @(negedge clk);
    end
    if (g_dones == 0) g_obs = bus.obstacles_out;
  endtask

  task automatic check_frame(input bit en, input logic [149:0] exp_obs,
                             input bit exp_coll, input bit exp_drop);
    check("done_count", 150'(g_dones), en ? 150'd1 : 150'd0);
    if (en) check("latency", 150'(g_first), 150'd13);
    check("stable", 150'(g_stable), 150'd1);
    check("obstacles", g_obs, exp_obs);
    check("collision", 150'(g_coll), 150'(exp_coll));
    check("dropped", 150'(g_drop), 150'(exp_drop));
  endtask

  // Model-driven frame: predict, run, compare
  task automatic model_run(input bit en, input int spd, input int pl, input bit pj,
                           input bit inject);
    logic [149:0] prev;
    bit hit, drop;
    prev = model_pack();
    hit  = 0;
    drop = 0;
    if (en) model_frame(spd, pl, pj, hit, drop);
    run_frame(en, spd, pl, pj, inject, prev);
    check_frame(en, model_pack(), hit, drop);
  endtask

  initial begin
    // Directed vectors: disabled ticks, two spawns at speed 3, a speed-0 frame
    for (int i = 0; i < 5; i++) vecs[i] = '{0, 3, 1, 0, 15'd0, 15'd0};
    vecs[5] = '{1, 3, 0, 0, 15'd8001, 15'd0};
    vecs[6] = '{1, 3, 2, 0, 15'd7977, 15'd24385};
    vecs[7] = '{1, 0, 1, 1, 15'd7977, 15'd24385};

    rst                = 1'b1;
    bus.enable_in      = 1'b0;
    bus.frame_tick_in  = 1'b0;
    bus.speed_in       = 3'd0;
    bus.player_lane_in = 2'd0;
    bus.player_jump_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_obstacles", bus.obstacles_out, 150'd0);
    check("reset_done", 150'(bus.update_done_out), 150'd0);
    check("reset_collision", 150'(bus.collision_out), 150'd0);
    check("reset_dropped", 150'(bus.spawn_dropped_out), 150'd0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      logic [149:0] prev;
      bit hit, drop;
      prev = model_pack();
      hit  = 0;
      drop = 0;
      if (vecs[v].en) model_frame(vecs[v].speed, vecs[v].lane, vecs[v].jump, hit, drop);
      run_frame(vecs[v].en, vecs[v].speed, vecs[v].lane, vecs[v].jump, 1'b0, prev);
      check_frame(vecs[v].en, model_pack(), hit, drop);
      check("vec_slot0", 150'(g_obs[14:0]), 150'(vecs[v].exp_s0));
      check("vec_slot1", 150'(g_obs[29:15]), 150'(vecs[v].exp_s1));
    end

    // Reset sampled at E0+6 while the update is in MOVE
    @(negedge clk);
    bus.enable_in     = 1'b1;
    bus.speed_in      = 3'd5;
    bus.frame_tick_in = 1'b1;
    @(negedge clk);
    bus.frame_tick_in = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_obstacles", bus.obstacles_out, 150'd0);
    check("midreset_done", 150'(bus.update_done_out), 150'd0);
    check("midreset_collision", 150'(bus.collision_out), 150'd0);
    check("midreset_dropped", 150'(bus.spawn_dropped_out), 150'd0);
    rst = 1'b0;
    model_reset();

    // Fill the table at speed 3; frame 11 finds no free slot, one frame has a busy tick
    for (int f = 0; f < 12; f++) model_run(1'b1, 3, 1, 1'b0, f == 10);

    // Randomized frames
    for (int f = 0; f < 700; f++) begin
      bit en, pj, inj;
      int spd, pl;
      en  = ($urandom_range(0, 9) != 0);
      spd = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(4, 7));
      pl  = int'($urandom_range(0, 2));
      pj  = 1'($urandom);
      inj = en && ($urandom_range(0, 7) == 0);
      model_run(en, spd, pl, pj, inj);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/obstacle_manager.md
Name: obstacle_manager

Overview:
- Produces the 10-slot obstacle array that feeds the track renderer, replacing the hard-coded table in the top level.
- On each accepted frame tick it moves every active obstacle toward the player, retires obstacles that pass position 0, spawns new obstacles from an LFSR, and flags collisions against the player lane and jump state.
- Updates are computed in a working copy and committed to the output in one cycle, so the renderer never sees a half-updated frame.

Parameters:
- SPAWN_POS, 10'd1000, position given to newly spawned obstacles.
- SPAWN_GAP, 11'd300, distance travelled between spawns.
- HIT_ZONE, 10'd16, a position strictly below this value is inside the player collision zone.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- system_clock_in  input  1  65 MHz system clock
- reset_in  input  1  synchronous, active-high reset
- enable_in  input  1  game running; when low, ticks are ignored
- frame_tick_in  input  1  one-cycle pulse per video frame (vcount==1 && hcount==1)
- speed_in  input  3  distance units moved per frame
- player_lane_in  input  2  player lane, 0..2
- player_jump_in  input  1  player airborne
- obstacles_out  output  150  slot i at [15*i+14:15*i]; slot format {type[14:13], position[12:3], lane[2:1], active[0]}
- update_done_out  output  1  one-cycle pulse on the commit cycle
- collision_out  output  1  one-cycle pulse, coincident with update_done_out, when any hit occurred in this frame
- spawn_dropped_out  output  1  one-cycle pulse, coincident with update_done_out, when a spawn found no free slot

Behaviour:
- Clock/reset: one clock, system_clock_in. reset_in is synchronous and active-high. Reset mid-update aborts the update with no commit.
- Reset values: all working slots and obstacles_out = 0; all pulse outputs = 0; state IDLE; distance accumulator (11b) = 0; slot index = 0; LFSR = LFSR_SEED.
- FSM states: IDLE, MOVE, SPAWN, COMMIT.
- IDLE:
  - If frame_tick_in && enable_in: latch speed_in, player_lane_in and player_jump_in; clear the hit and dropped flags; set idx=0; go to MOVE.
  - A tick arriving in any other state, or with enable_in low, is ignored (no queuing).
- MOVE: processes one slot per cycle, idx 0..9, for 10 cycles; after idx 9, go to SPAWN.
  - Inactive slot: unchanged.
  - Active slot with pos < speed: slot cleared to 15'b0.
  - Otherwise pos <= pos - speed. pos == speed yields pos 0 and the slot stays active.
  - After the move, the slot is a hit when: still active, new pos < HIT_ZONE, lane == latched player lane, and NOT (type == 2'b01 && latched jump). Type 01 is jumpable.
  - A hit sets the hit flag and clears the slot, so the same obstacle cannot collide twice.
- SPAWN, one cycle:
  - Advance the LFSR once: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, shift right, feedback mask 16'hB400.
  - sum = distance + speed (11b, no overflow since SPAWN_GAP <= 2047-7).
  - If sum >= SPAWN_GAP: distance <= sum - SPAWN_GAP and spawn. Otherwise distance <= sum.
  - Spawn target is the lowest-index inactive slot. It is written {new_lfsr[3:2], SPAWN_POS, lane, 1'b1}, where lane = new_lfsr[1:0], except that value 3 maps to lane 0.
  - No free slot: set the dropped flag; distance is still reduced.
  - speed 0: nothing moves or spawns, but the LFSR still advances.
- COMMIT, one cycle:
  - obstacles_out <= working array.
  - update_done_out = 1, collision_out = hit flag, spawn_dropped_out = dropped flag.
  - Go to IDLE.
- Latency: tick sampled at edge E0 → outputs reflect the new frame after edge E0+12. Busy for 12 cycles; the next accepted tick is at E0+12 or later.
- Stability: obstacles_out changes only in COMMIT (or on reset) and is stable for the rest of the frame.
- Width rules:
  - Position is a 10-bit unsigned value; subtraction is guarded by the pos < speed test, so there is no wrap-around.
  - The slot index is 4 bits and never exceeds 9.

Test Plan:
- Reset, then 5 ticks with enable_in=0 → obstacles_out stays 0, no update_done_out pulse, LFSR unchanged.
- Pre-load via 1 spawn: speed=3, SPAWN_GAP=3, seed 16'hACE1 → after E0+12, slot0 = {lfsr[3:2], 1000, lane-from-lfsr, 1} matching the reference model; next tick moves it to 997.
- Underflow: obstacle at pos 2, speed 3 → slot cleared to 0. Obstacle at pos 3, speed 3 → pos 0, still active.
- Collision: obstacle type 00, lane 1, pos 18, speed 3, player_lane 1, jump 0 → collision_out pulses with update_done_out and the slot is cleared. Same obstacle with type 01 and jump 1 → no collision, pos 15 retained.
- Full table: all 10 slots active at pos 900, distance crosses SPAWN_GAP → spawn_dropped_out=1 and no slot is overwritten. A tick issued at E0+5 during the update → ignored, exactly one update_done_out pulse.
- reset_in asserted at E0+6 mid-MOVE → next cycle all outputs 0, state IDLE; a subsequent tick completes normally in 12 cycles.
